// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave: word-addressed register array with byte-lane writes, read-only masking and range errors.
// Latency: ack_o/err_o rises WAIT_STATES+1 edges after the request edge and is high for exactly one cycle.
// Backpressure: the request is held off by withholding ack_o/err_o; dropping cyc_i/stb_i while waiting aborts it.
module wb_slave_regfile #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                    DATA_COUNT   = 16,
    parameter int                    WAIT_STATES  = 0,
    parameter logic [DATA_COUNT-1:0] RO_MASK      = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    req_we;
    logic [LANES-1:0]        req_sel;
    logic [DATA_WIDTH-1:0]   req_dat;
    logic [IDX_W-1:0]        req_idx;
    logic                    req_err;
    logic [DATA_WIDTH-1:0]   mem [DATA_COUNT];

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    below_base;
    logic                    past_end;
    logic                    ro_hit;
    logic                    req_start;

    // Decode the live request: word offset from the base and the error conditions.
    // The read-only lookup only matters when the offset is in range; otherwise past_end already flags it.
    always_comb begin
        offset     = adr_i - BASE_ADDRESS;
        below_base = adr_i < BASE_ADDRESS;
        past_end   = offset >= ADDR_WIDTH'(DATA_COUNT);
        ro_hit     = 1'b0;
        if (!past_end) begin
            ro_hit = RO_MASK[offset[IDX_W-1:0]];
        end
        req_start  = cyc_i && stb_i;
    end

    // Transfer FSM: capture, optional wait countdown with abort, then a single response edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            dat_o   <= '0;
            req_we  <= 1'b0;
            req_sel <= '0;
            req_dat <= '0;
            req_idx <= '0;
            req_err <= 1'b0;
            for (int i = 0; i < DATA_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    if (req_start) begin
                        req_we  <= we_i;
                        req_sel <= sel_i;
                        req_dat <= dat_i;
                        req_idx <= offset[IDX_W-1:0];
                        req_err <= below_base || past_end || (we_i && ro_hit);
                        if (WAIT_STATES > 0) begin
                            cnt   <= CW'(WAIT_STATES);
                            state <= S_WAIT;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    // Master gave up: drop the request without touching the array or outputs.
                    if (!req_start) begin
                        state <= S_IDLE;
                    end else if (cnt == CW'(1)) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    // Response edge: errors leave state untouched, writes merge enabled lanes only.
                    if (req_err) begin
                        err_o <= 1'b1;
                    end else begin
                        ack_o <= 1'b1;
                        if (req_we) begin
                            for (int b = 0; b < LANES; b++) begin
                                if (req_sel[b]) begin
                                    mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
                                end
                            end
                        end else begin
                            dat_o <= mem[req_idx];
                        end
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
